alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single 16-bit Alu instance between two requesters: port 0 (CPU datapath) and port 1 (game-logic/graphics helper). Uses a valid/ready request handshake, round-robin grant, registered operands, and a held response. The block sits between the requesters and the Alu. It drives the Alu's a, b and alucode, and captures its result and flags.

Parameters:
WIDTH, 16, operand/result width
CODE_W, 4, alucode width
FLAG_W, 5, flags width
FIRST_PRI, 0, requester favoured by round-robin after reset (0 or 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a, req0_b  input  WIDTH  requester 0 operands
req0_code  input  CODE_W  requester 0 alucode
rsp0_valid  output  1  requester 0 result available
rsp0_ready  input  1  requester 0 consumes result
req1_valid, req1_ready, req1_a, req1_b, req1_code, rsp1_valid, rsp1_ready  (same as port 0, for requester 1)
rsp_result  output  WIDTH  shared result register (meaningful only with rspN_valid)
rsp_flags  output  FLAG_W  shared flags register
alu_a, alu_b  output  WIDTH  to Alu a, b
alu_code  output  CODE_W  to Alu alucode
alu_result  input  WIDTH  from Alu result (combinational)
alu_flags  input  FLAG_W  from Alu flags
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high) forces the following, overriding all other activity including mid-operation:
  - state = IDLE.
  - alu_a, alu_b, alu_code, rsp_result, rsp_flags = 0.
  - rsp0_valid = rsp1_valid = 0, busy = 0.
  - Last-served pointer = 1 - FIRST_PRI.
  - Any in-flight operation is dropped with no response.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational and asserts only for the granted requester.
  - Grant rule: if exactly one reqN_valid is high, grant it. If both are high, grant the requester other than the last-served pointer.
  - On grant, register a, b and code into alu_a/alu_b/alu_code, record grant id, and go to EXEC.
  - With no valid request, remain in IDLE and hold the alu_* registers.
- EXEC (one cycle): the Alu evaluates the registered operands. At the clock edge, capture alu_result -> rsp_result and alu_flags -> rsp_flags, then go to RESP.
- RESP:
  - rspG_valid = 1 for the granted requester only; the other rsp valid stays 0.
  - Hold rsp_result, rsp_flags and alu_* stable until rspG_ready = 1.
  - In that cycle, set last-served = G and go to IDLE. rspG_valid drops on the next cycle.
- Latency: accept in cycle N, rsp valid in cycle N+2 with a zero-wait consumer.
- Throughput: at most one operation per 3 cycles. No request is accepted outside IDLE, so reqN_ready = 0 in EXEC and RESP.
- Requester obligations:
  - reqN_a, reqN_b and reqN_code are sampled only in the accept cycle.
  - A requester holds valid and its data until ready.
- The arbiter does not decode alucode. Undefined codes pass through, and whatever the Alu produces is returned.
- rsp_ready asserted while the matching rsp_valid = 0 is ignored.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1… starting with FIRST_PRI.

Test Plan:
- Single op, port 0: a=0x0003, b=0x0001, code=0000 (add), rsp0_ready=1 → req0_ready in cycle N; rsp0_valid in N+2 with rsp_result=0x0004; rsp1_valid stays 0.
- Compare flags, port 1: a=0x0003, b=0x0004, code=0010 → rsp_flags=5'b00011. Then a=b=0x0001 → rsp_flags=5'b10000. Then a=0x0003, b=0x0001 → rsp_flags=5'b00000.
- Simultaneous requests after reset (FIRST_PRI=0): port 0 sub 3-1, port 1 xor 1^0, both held valid → port 0 served first (result 0x0002), then port 1 (result 0x0001). A further simultaneous pair is served 0 then 1 again.
- Backpressure: port 0 LUI a=0x0f0f, b=0xFFFF, rsp0_ready low for 5 cycles → rsp0_valid and rsp_result stable through all 5 cycles; req1_ready stays 0 throughout despite req1_valid=1; port 1 is granted the cycle after rsp0_ready rises.
- Reset mid-operation: assert reset in EXEC → next cycle state IDLE, busy=0, all rsp valid 0, alu_* and rsp_result 0; no response is delivered for the dropped operation.
- Idle hold: no requests for 10 cycles → alu_a/alu_b/alu_code unchanged from the last operation, busy=0, all ready/valid outputs 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one Alu between two valid/ready requesters.
// Operands are registered on accept, the result is captured one cycle later and held until consumed.
module alu_arbiter #(
   parameter int WIDTH     = 16,
   parameter int CODE_W    = 4,
   parameter int FLAG_W    = 5,
   parameter bit FIRST_PRI = 1'b0
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [WIDTH-1:0]  req0_a,
   input  logic [WIDTH-1:0]  req0_b,
   input  logic [CODE_W-1:0] req0_code,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [WIDTH-1:0]  req1_a,
   input  logic [WIDTH-1:0]  req1_b,
   input  logic [CODE_W-1:0] req1_code,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,

   output logic [WIDTH-1:0]  rsp_result,
   output logic [FLAG_W-1:0] rsp_flags,

   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [CODE_W-1:0] alu_code,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic [FLAG_W-1:0] alu_flags,

   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic grant_valid;
   logic grant_sel;
   logic grant_id;
   logic last_served;
   logic accept;
   logic rsp_fire;

   // On contention the requester that was not served last wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_sel   = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_valid = 1'b1;
         grant_sel   = ~last_served;
      end else if (req0_valid) begin
         grant_valid = 1'b1;
         grant_sel   = 1'b0;
      end else if (req1_valid) begin
         grant_valid = 1'b1;
         grant_sel   = 1'b1;
      end
   end

   assign rsp_fire = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid && !reset) begin
               accept     = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            state_next = RESP;
         end
         RESP: begin
            if (rsp_fire) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand, response and fairness registers; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_code    <= '0;
         rsp_result  <= '0;
         rsp_flags   <= '0;
         grant_id    <= 1'b0;
         last_served <= ~FIRST_PRI;
      end else begin
         if (accept) begin
            alu_a    <= grant_sel ? req1_a    : req0_a;
            alu_b    <= grant_sel ? req1_b    : req0_b;
            alu_code <= grant_sel ? req1_code : req0_code;
            grant_id <= grant_sel;
         end
         if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
         end
         if (rsp_fire) begin
            last_served <= grant_id;
         end
      end
   end

   assign req0_ready = accept && !grant_sel;
   assign req1_ready = accept &&  grant_sel;
   assign rsp0_valid = (state == RESP) && !grant_id;
   assign rsp1_valid = (state == RESP) &&  grant_id;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a small Alu model on the alu_* side, a transaction-level
// reference model compared every cycle, and directed vectors with literal expectations.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_code, req1_code;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0Rdy, rsp1Rdy;
   logic [15:0] rsp_result;
   logic [4:0]  rsp_flags;
   logic [15:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_code;
   logic [4:0]  alu_flags;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit checkEnable = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_arbiter #(.WIDTH(16), .CODE_W(4), .FLAG_W(5), .FIRST_PRI(1'b0)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_code(req0_code), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0Rdy),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_code(req1_code), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1Rdy),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
      .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
   );

   // Stand-in Alu: flags = {zero, 2'b0, unsigned less-than, signed less-than}, compares set the lt bits.
   function automatic logic [20:0] aluFn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] code);
      logic [15:0] r;
      logic [4:0]  f;
      f = '0;
      case (code)
         4'h0: r = a + b;
         4'h1: r = a - b;
         4'h2: begin
            r    = a - b;
            f[1] = (a < b);
            f[0] = ($signed(a) < $signed(b));
         end
         4'h4: r = a ^ b;
         4'h5: r = {a[7:0], 8'h00};
         default: r = a & b;
      endcase
      f[4] = (r == 16'h0000);
      return {f, r};
   endfunction

   assign {alu_flags, alu_result} = aluFn(alu_a, alu_b, alu_code);

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: one outstanding transaction with an age since acceptance.
   bit          mInflight = 1'b0;
   int          mAge = 0;
   bit          mOwner = 1'b0;
   bit          mLast = 1'b1;
   logic [15:0] mA = '0, mB = '0, mRes = '0;
   logic [3:0]  mCode = '0;
   logic [4:0]  mFlags = '0;

   function automatic int pickGrant(input bit v0, input bit v1, input bit lastServed);
      if (v0 && v1) return lastServed ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   int          g;
   bit          sReset, sR0, sR1;
   logic [15:0] sA0, sB0, sA1, sB1;
   logic [3:0]  sC0, sC1;

   initial begin
      wait (checkEnable);
      forever begin
         @(negedge clk);
         g = (mInflight || reset) ? -1 : pickGrant(req0_valid, req1_valid, mLast);
         checkOutput("busy",       32'(busy),       32'(mInflight));
         checkOutput("req0_ready", 32'(req0_ready), 32'(g == 0));
         checkOutput("req1_ready", 32'(req1_ready), 32'(g == 1));
         checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(mInflight && mAge == 2 && !mOwner));
         checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(mInflight && mAge == 2 && mOwner));
         checkOutput("alu_a",      32'(alu_a),      32'(mA));
         checkOutput("alu_b",      32'(alu_b),      32'(mB));
         checkOutput("alu_code",   32'(alu_code),   32'(mCode));
         checkOutput("rsp_result", 32'(rsp_result), 32'(mRes));
         checkOutput("rsp_flags",  32'(rsp_flags),  32'(mFlags));
         sReset = reset; sR0 = rsp0Rdy; sR1 = rsp1Rdy;
         sA0 = req0_a; sB0 = req0_b; sC0 = req0_code;
         sA1 = req1_a; sB1 = req1_b; sC1 = req1_code;
         @(posedge clk);
         if (sReset) begin
            mInflight = 1'b0; mAge = 0; mLast = 1'b1;
            mA = '0; mB = '0; mCode = '0; mRes = '0; mFlags = '0;
         end else if (!mInflight) begin
            if (g >= 0) begin
               mInflight = 1'b1; mAge = 1; mOwner = (g == 1);
               mA = mOwner ? sA1 : sA0; mB = mOwner ? sB1 : sB0; mCode = mOwner ? sC1 : sC0;
            end
         end else if (mAge == 1) begin
            {mFlags, mRes} = aluFn(mA, mB, mCode);
            mAge = 2;
         end else if (mOwner ? sR1 : sR0) begin
            mInflight = 1'b0;
            mLast = mOwner;
         end
      end
   end

   // Drives one request until accepted; returns at posedge+2 after the accepting edge.
   task automatic applyStimulus(input int port, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] code, output int acceptCyc);
      bit done = 1'b0;
      acceptCyc = -1;
      if (port == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_code = code; end
      else           begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_code = code; end
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if ((port == 0) ? req0_ready : req1_ready) begin
            acceptCyc = cyc;
            done = 1'b1;
         end
         @(posedge clk); #2;
      end
      if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitRsp(input int port, input logic [15:0] expRes, input logic [4:0] expFlags,
                          output int rspCyc);
      bit done = 1'b0;
      rspCyc = -1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if ((port == 0) ? rsp0_valid : rsp1_valid) begin
            rspCyc = cyc;
            done = 1'b1;
            checkOutput("lit_result", 32'(rsp_result), 32'(expRes));
            checkOutput("lit_flags",  32'(rsp_flags),  32'(expFlags));
         end
      end
      if (!done) checkOutput("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
   endtask

   int acc0, acc1, r0, r1, hsCyc;

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_code = '0;
      req1_a = '0; req1_b = '0; req1_code = '0;
      rsp0Rdy = 1'b1; rsp1Rdy = 1'b1;
      @(posedge clk); #2;
      checkEnable = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_busy",   32'(busy),       32'd0);
      checkOutput("reset_rsp0",   32'(rsp0_valid), 32'd0);
      checkOutput("reset_result", 32'(rsp_result), 32'd0);
      @(posedge clk); #2;

      $display("[TB] single add on port 0");
      fork
         applyStimulus(0, 16'h0003, 16'h0001, 4'h0, acc0);
         waitRsp(0, 16'h0004, 5'b00000, r0);
      join
      checkOutput("latency", 32'(r0 - acc0), 32'd2);
      @(posedge clk); #2;

      $display("[TB] compare flags on port 1");
      fork applyStimulus(1, 16'h0003, 16'h0004, 4'h2, acc1); waitRsp(1, 16'hFFFF, 5'b00011, r1); join
      @(posedge clk); #2;
      fork applyStimulus(1, 16'h0001, 16'h0001, 4'h2, acc1); waitRsp(1, 16'h0000, 5'b10000, r1); join
      @(posedge clk); #2;
      fork applyStimulus(1, 16'h0003, 16'h0001, 4'h2, acc1); waitRsp(1, 16'h0002, 5'b00000, r1); join
      @(posedge clk); #2;

      $display("[TB] simultaneous requests after reset");
      doReset();
      for (int k = 0; k < 2; k++) begin
         fork
            applyStimulus(0, 16'h0003, 16'h0001, 4'h1, acc0);
            applyStimulus(1, 16'h0001, 16'h0000, 4'h4, acc1);
            waitRsp(0, 16'h0002, 5'b00000, r0);
            waitRsp(1, 16'h0001, 5'b00000, r1);
         join
         checkOutput("order_0_before_1", 32'(r0 < r1), 32'd1);
         @(posedge clk); #2;
      end

      $display("[TB] backpressure on port 0");
      rsp0Rdy = 1'b0;
      applyStimulus(0, 16'h0f0f, 16'hFFFF, 4'h5, acc0);
      fork applyStimulus(1, 16'h0005, 16'h0006, 4'h0, acc1); join_none
      @(negedge clk);
      checkOutput("bp_exec_req1_ready", 32'(req1_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_rsp0_valid",  32'(rsp0_valid), 32'd1);
         checkOutput("bp_rsp_result",  32'(rsp_result), 32'h0f00);
         checkOutput("bp_req1_ready",  32'(req1_ready), 32'd0);
      end
      @(posedge clk); #2;
      rsp0Rdy = 1'b1;
      @(negedge clk);
      hsCyc = cyc;
      checkOutput("bp_hs_req1_ready", 32'(req1_ready), 32'd0);
      @(negedge clk);
      checkOutput("bp_grant1_next", 32'(req1_ready), 32'd1);
      waitRsp(1, 16'h000b, 5'b00000, r1);
      checkOutput("bp_accept_cycle", 32'(acc1), 32'(hsCyc + 1));
      @(posedge clk); #2;

      $display("[TB] reset during EXEC");
      applyStimulus(0, 16'h0007, 16'h0002, 4'h0, acc0);
      doReset();
      @(negedge clk);
      checkOutput("mid_busy",     32'(busy),       32'd0);
      checkOutput("mid_rsp0",     32'(rsp0_valid), 32'd0);
      checkOutput("mid_rsp1",     32'(rsp1_valid), 32'd0);
      checkOutput("mid_alu_a",    32'(alu_a),      32'd0);
      checkOutput("mid_alu_code", 32'(alu_code),   32'd0);
      checkOutput("mid_result",   32'(rsp_result), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("mid_no_rsp", 32'(rsp0_valid), 32'd0);
      end
      @(posedge clk); #2;

      $display("[TB] idle hold");
      fork applyStimulus(1, 16'h1234, 16'h0001, 4'h0, acc1); waitRsp(1, 16'h1235, 5'b00000, r1); join
      @(posedge clk); #2;
      for (int i = 0; i < 10; i++) @(negedge clk);
      checkOutput("hold_alu_a",    32'(alu_a),    32'h1234);
      checkOutput("hold_alu_b",    32'(alu_b),    32'h0001);
      checkOutput("hold_alu_code", 32'(alu_code), 32'h0);
      checkOutput("hold_busy",     32'(busy),     32'd0);
      checkOutput("hold_handshake", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 32'd0);

      @(posedge clk); #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

endmodule
